// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit datapath.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_adder2.sv
// adder2: plain 4-bit ripple-carry adder reused as the serial adder's datapath.
module adder2
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one operand pair is pushed through a single adder2,
// one nibble per cycle LSB first, with the carry held in a register between nibbles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [WIDTH-1:0]    nib_ext;

    adder2 u_adder2 (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Zero-extended so the MSB-end insertion also works when WIDTH == NIBBLE_W.
    assign nib_ext  = WIDTH'(nib_sum);

    assign in_ready = (state_q == IDLE) & ~rst;
    assign sum      = result_q;
    assign cout     = carry_q;

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d = (result_q >> NIBBLE_W) | (nib_ext << (WIDTH - NIBBLE_W));
                carry_d  = nib_cout;
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_NIB) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

- Sequential WIDTH-bit adder.
- Accepts one operand pair through a valid/ready handshake and feeds it nibble-by-nibble, LSB first, into a single 4-bit ripple adder (adder2).
- Registers the carry between nibbles and assembles the sum.
- Sits directly upstream of adder2, reusing it as the datapath instead of instantiating WIDTH/4 copies: trades latency for area.

## Interface

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into nibble 0.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB nibble.

## Operation

- States: IDLE, ADD, DONE.
- in_ready = (state == IDLE) & ~rst.
- Input accept, IDLE & in_valid & in_ready:
  - a and b load into shift registers.
  - Carry register loads cin.
  - Nibble counter clears to 0.
  - State moves to ADD.
- ADD, each cycle:
  - adder2 adds a_sh[3:0], b_sh[3:0] and the carry register.
  - The sum nibble shifts into the result register from the MSB end.
  - The carry register takes adder2's Cout.
  - a_sh and b_sh shift right by 4.
  - The counter increments.
- On the ADD cycle where counter == NIBBLES-1, state moves to DONE.
- DONE:
  - out_valid = 1; sum = result register; cout = carry register.
  - Both held stable until out_ready.
  - On out_valid & out_ready, state moves to IDLE.
- a, b, cin and in_valid are ignored outside IDLE.
- out_ready is ignored outside DONE.
- Arithmetic: exact WIDTH+1-bit result; {cout, sum} == a + b + cin. No signed interpretation.
- Reset asserted in any state, including mid-ADD: at the next edge, state is IDLE and the operation is discarded; no out_valid pulse is produced.
- Reset values:
  - state IDLE; out_valid 0; sum 0; cout 0.
  - Carry register and counter 0.
  - in_ready 0 while rst is high, 1 from the first cycle after release.

## Timing

- Accept edge = edge E.
- ADD occupies edges E+1 … E+NIBBLES.
- out_valid is high from the cycle after edge E+NIBBLES.
- Latency, accept to out_valid: NIBBLES cycles (4 for WIDTH=16).
- With out_ready held high, out_valid lasts exactly 1 cycle, and in_ready returns the following cycle.
- Minimum initiation interval: NIBBLES+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- The only combinational logic between registers is adder2 plus the shift/mux logic: one 4-bit ripple per cycle.

## Structure

- Shared package holds:
  - the state enum (IDLE, ADD, DONE);
  - the constant NIBBLE_W = 4.
- One sub-module instance: adder2 (existing 4-bit ripple adder), wired to the low nibbles of the shift registers and the carry register.
- No other hierarchy. FSM, shift registers, counter and result register live in nibble_serial_adder.
- Counter width: $clog2(NIBBLES), minimum 1.

## Test plan

All scenarios use WIDTH=16.

- Reset: hold rst 3 cycles, release -> out_valid=0, sum=0, cout=0 throughout; in_ready=1 on the first cycle after release.
- Basic: a=16'h1234, b=16'h4321, cin=0 -> out_valid exactly 4 cycles after accept; sum=16'h5555, cout=0.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Also a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Backpressure:
  - Stimulus: a=16'h0F0F, b=16'h00F1, cin=0, with out_ready low 10 cycles after out_valid rises.
  - Response: sum=16'h1000 and cout=0 held stable; in_ready=0 throughout.
  - A different a/b presented with in_valid during the stall is not accepted.
  - Raising out_ready completes the transfer in one cycle.
- Reset mid-op:
  - Stimulus: assert rst on the 2nd ADD cycle of a=16'hAAAA, b=16'h5555.
  - Response: no out_valid pulse ever.
  - The next transaction, a=16'h0001, b=16'h0001, cin=1, yields sum=16'h0003, cout=0.
- Randomised back-to-back: 1000 random a/b/cin with random in_valid/out_ready gaps -> every {cout, sum} equals a+b+cin; transaction order preserved; no drops or duplicates.
